// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data types, builder FSM states,
// header ECC and per-byte CRC-16 helpers.
package csi2_pkg;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FS,
    ST_LH,
    ST_PAY,
    ST_CRC,
    ST_FE
  } state_t;

  // 6-bit Hamming parity over {WC_MSB, WC_LSB, DI}
  function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10]
         ^ d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10]
         ^ d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11]
         ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13]
         ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16]
         ^ d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15]
         ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return {2'b00, p};
  endfunction

  // x^16+x^12+x^5+1, bits taken LSB-first (reflected form 0x8408)
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  b
  );
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Running CRC-16 over long-packet payload bytes.
// Re-seeded to 0xFFFF while i_init is high.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_crc <= 16'hFFFF;
    else if (i_init) r_crc <= 16'hFFFF;
    else if (i_en)   r_crc <= crc16_byte(r_crc, i_byte);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/csi2_packet_builder.sv
// CSI-2 TX framer: pixel bytes in, FS / long packets / FE bytes out
// through a single output register stage.
module csi2_packet_builder
  import csi2_pkg::*;
#(
  parameter int         LINE_BYTES = 512,
  parameter int         LINES      = 16,
  parameter logic [5:0] DATA_TYPE  = DT_RAW8,
  parameter logic [1:0] VC         = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        frame_active,
  output logic [15:0] frame_num,
  output logic        err_len,
  output logic        err_sof
);

  localparam logic [15:0] WC        = 16'(LINE_BYTES);
  localparam logic [15:0] PAY_LAST  = 16'(LINE_BYTES - 1);
  localparam logic [15:0] LINE_LAST = 16'(LINES - 1);

  state_t      r_state, w_state_nx;
  logic [1:0]  r_idx;
  logic [15:0] r_byte_cnt, r_line_cnt, r_frame_num;
  logic        r_tvalid, r_tlast, r_tuser, r_active;
  logic        r_err_len, r_err_sof;
  logic [7:0]  r_tdata;

  logic        w_free, w_accept, w_load, w_s_ready;
  logic        w_first, w_last;
  logic        w_hdr_end, w_crc_end, w_pay_end;
  logic [7:0]  w_byte, w_di, w_ecc, w_hdr_byte;
  logic [15:0] w_wc, w_crc;

  assign w_free    = !r_tvalid || m_axis_tready;
  assign w_accept  = (r_state == ST_PAY) && s_axis_tvalid && w_free;
  assign w_hdr_end = r_idx == 2'd3;
  assign w_crc_end = r_idx == 2'd1;
  assign w_pay_end = r_byte_cnt == PAY_LAST;

  always_comb begin
    w_di = {VC, DT_FS};
    w_wc = r_frame_num;
    case (r_state)
      ST_FE: w_di = {VC, DT_FE};
      ST_LH: begin
        w_di = {VC, DATA_TYPE};
        w_wc = WC;
      end
      default: ;
    endcase
  end

  assign w_ecc = csi2_ecc({w_wc, w_di});

  always_comb begin
    case (r_idx)
      2'd0:    w_hdr_byte = w_di;
      2'd1:    w_hdr_byte = w_wc[7:0];
      2'd2:    w_hdr_byte = w_wc[15:8];
      default: w_hdr_byte = w_ecc;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_s_ready  = 1'b0;
    w_load     = 1'b0;
    w_byte     = w_hdr_byte;
    w_first    = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready = !s_axis_tuser;
        if (s_axis_tvalid && s_axis_tuser) w_state_nx = ST_FS;
      end
      ST_FS: begin
        w_load  = w_free;
        w_first = r_idx == 2'd0;
        if (w_free && w_hdr_end) w_state_nx = ST_LH;
      end
      ST_LH: begin
        w_load = w_free;
        if (w_free && w_hdr_end) w_state_nx = ST_PAY;
      end
      ST_PAY: begin
        w_s_ready = w_free;
        w_load    = w_accept;
        w_byte    = s_axis_tdata;
        if (w_accept && w_pay_end) w_state_nx = ST_CRC;
      end
      ST_CRC: begin
        w_load = w_free;
        w_byte = w_crc_end ? w_crc[15:8] : w_crc[7:0];
        if (w_free && w_crc_end)
          w_state_nx = (r_line_cnt == LINE_LAST) ? ST_FE : ST_LH;
      end
      ST_FE: begin
        w_load = w_free;
        w_last = w_hdr_end;
        if (w_free && w_hdr_end) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_byte_cnt  <= 16'd0;
      r_line_cnt  <= 16'd0;
      r_frame_num <= 16'd0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == ST_IDLE && w_state_nx == ST_FS) begin
        // frame number 0 is reserved, so the wrap skips it
        r_frame_num <= (r_frame_num == 16'hFFFF) ? 16'd1
                                                 : r_frame_num + 16'd1;
        r_line_cnt  <= 16'd0;
      end
      if (w_load) begin
        case (r_state)
          ST_FS, ST_LH, ST_FE: r_idx <= r_idx + 2'd1;
          ST_CRC: begin
            r_idx <= w_crc_end ? 2'd0 : 2'd1;
            if (w_crc_end) r_line_cnt <= r_line_cnt + 16'd1;
          end
          ST_PAY: r_byte_cnt <= w_pay_end ? 16'd0 : r_byte_cnt + 16'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= 8'h00;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_active  <= 1'b0;
      r_err_len <= 1'b0;
      r_err_sof <= 1'b0;
    end else begin
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_byte;
        r_tlast  <= w_last;
        r_tuser  <= w_first;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
      if (w_load && w_first)
        r_active <= 1'b1;
      else if (r_tvalid && m_axis_tready && r_tlast)
        r_active <= 1'b0;
      r_err_len <= w_accept && (s_axis_tlast != w_pay_end);
      // the frame's first byte legitimately still carries TUSER
      r_err_sof <= w_accept && s_axis_tuser &&
                   !(r_byte_cnt == 16'd0 && r_line_cnt == 16'd0);
    end
  end

  csi2_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .i_init (r_state == ST_LH),
    .i_en   (w_accept),
    .i_byte (s_axis_tdata),
    .o_crc  (w_crc)
  );

  assign s_axis_tready = w_s_ready && !rst;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign frame_active  = r_active;
  assign frame_num     = r_frame_num;
  assign err_len       = r_err_len;
  assign err_sof       = r_err_sof;

endmodule

// File: tb/tb_csi2_packet_builder.sv
// Scoreboard bench for csi2_packet_builder: frames built from a byte-level
// model of CSI-2 framing, compared by an independent output monitor.
`timescale 1ns/1ps
module tb_csi2_packet_builder;

  localparam int LB = 24;
  localparam int LN = 6;
  localparam int FRAME_BYTES = 8 + LN * (LB + 6);

  // parity-matrix column for each header bit D0..D23
  localparam logic [5:0] COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  localparam logic [7:0] MIPI_VEC [24] = '{
    8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
    8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
    8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0]  s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        frame_active, err_len, err_sof;
  logic [15:0] frame_num;

  always #5 clk = ~clk;

  csi2_packet_builder #(
    .LINE_BYTES (LB),
    .LINES      (LN),
    .DATA_TYPE  (6'h2A),
    .VC         (2'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_active  (frame_active),
    .frame_num     (frame_num),
    .err_len       (err_len),
    .err_sof       (err_sof)
  );

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q [$];
  logic [9:0]  cap [$];
  int          n_len = 0;
  int          n_sof = 0;
  bit          stall_en = 1'b0;
  logic [15:0] model_fn = 16'd0;
  logic [15:0] crc_tab [256];
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_out = 10'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] m_ecc(input logic [23:0] d);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < 24; i++)
      if (d[i]) s ^= COL[i];
    return {2'b00, s};
  endfunction

  function automatic logic [15:0] m_crc(input logic [15:0] c,
                                        input logic [7:0] b);
    return (c >> 8) ^ crc_tab[c[7:0] ^ b];
  endfunction

  task automatic exp_hdr(input logic [7:0] di, input logic [15:0] wc,
                         input bit u, input bit l);
    exp_q.push_back({u, 1'b0, di});
    exp_q.push_back({2'b00, wc[7:0]});
    exp_q.push_back({2'b00, wc[15:8]});
    exp_q.push_back({1'b0, l, m_ecc({wc, di})});
  endtask

  // downstream ready: always 1, or a coin flip per cycle
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // output monitor: scoreboard pops, hold-during-stall, error pulses
  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] e;
    cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {21'd0, m_axis_tvalid, cur}, {21'd0, 1'b1, prev_out});
      if (err_len) n_len++;
      if (err_sof) n_sof++;
      if (m_axis_tvalid && m_axis_tready) begin
        cap.push_back(cur);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h required none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("stream_byte", {22'd0, cur}, {22'd0, e});
        end
        if (m_axis_tuser) chk("active_at_fs", {31'd0, frame_active}, 32'd1);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = cur;
    end
  end

  task automatic put(input logic [7:0] d, input bit u, input bit l,
                     input bit gaps, output bit ok);
    int n;
    ok = 1'b1;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL put_timeout: byte %02h not taken, required within 3000", d);
        s_axis_tvalid = 1'b0;
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    chk("abort_outputs",
        {1'b0, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
         m_axis_tuser, frame_active, frame_num, err_len, err_sof}, 32'd0);
    exp_q.delete();
    model_fn = 16'd0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 1'b0;
    repeat (4) begin
      s_axis_tdata = 8'($urandom);
      @(negedge clk);
      chk("idle_ready", {31'd0, s_axis_tready}, 32'd1);
      chk("idle_no_output", {31'd0, m_axis_tvalid}, 32'd0);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  // kind: 0 incrementing, 1 random, 2 reference CRC vector on line 0,
  // 3 misplaced TLAST, 4 mid-frame TUSER, 5 reset during line 5
  task automatic run_frame(input int kind, input bit gaps);
    logic [7:0]  pay [LN][LB];
    bit          tl  [LN][LB];
    bit          tu  [LN][LB];
    logic [15:0] crc;
    int          el, es;
    bit          ok;
    el = 0;
    es = 0;
    model_fn = (model_fn == 16'hFFFF) ? 16'd1 : model_fn + 16'd1;
    for (int l = 0; l < LN; l++) begin
      for (int b = 0; b < LB; b++) begin
        case (kind)
          0:       pay[l][b] = 8'(l * LB + b);
          2:       pay[l][b] = (l == 0) ? MIPI_VEC[b] : 8'(l * LB + b);
          default: pay[l][b] = 8'($urandom);
        endcase
        tl[l][b] = (b == LB - 1);
        tu[l][b] = (l == 0 && b == 0);
      end
    end
    if (kind == 3) begin
      tl[0][10]     = 1'b1;
      tl[2][LB - 1] = 1'b0;
      el = 2;
    end
    if (kind == 4) begin
      tu[1][5] = 1'b1;
      es = 1;
    end
    exp_hdr(8'h00, model_fn, 1'b1, 1'b0);
    for (int l = 0; l < LN; l++) begin
      exp_hdr(8'h2A, 16'(LB), 1'b0, 1'b0);
      crc = 16'hFFFF;
      for (int b = 0; b < LB; b++) begin
        exp_q.push_back({2'b00, pay[l][b]});
        crc = m_crc(crc, pay[l][b]);
      end
      exp_q.push_back({2'b00, crc[7:0]});
      exp_q.push_back({2'b00, crc[15:8]});
    end
    exp_hdr(8'h01, model_fn, 1'b0, 1'b1);
    cap.delete();
    n_len = 0;
    n_sof = 0;
    for (int l = 0; l < LN; l++) begin
      for (int b = 0; b < LB; b++) begin
        if (kind == 5 && l == 5 && b == 8) begin
          mid_reset();
          return;
        end
        put(pay[l][b], tu[l][b], tl[l][b], gaps, ok);
        if (!ok) begin
          exp_q.delete();
          return;
        end
      end
    end
    drain();
    chk("frame_len", cap.size(), FRAME_BYTES);
    chk("err_len_pulses", n_len, el);
    chk("err_sof_pulses", n_sof, es);
    chk("frame_num", {16'd0, frame_num}, {16'd0, model_fn});
    chk("frame_active_end", {31'd0, frame_active}, 32'd0);
  endtask

  initial begin
    for (int v = 0; v < 256; v++) begin
      logic [15:0] c;
      c = 16'(v);
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      crc_tab[v] = c;
    end
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {1'b0, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
         m_axis_tuser, frame_active, frame_num, err_len, err_sof}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(2, 1'b0);
    chk("fs_di", {22'd0, cap[0]}, 32'h200);
    chk("fs_wc_lsb", {22'd0, cap[1]}, 32'h001);
    chk("fs_wc_msb", {22'd0, cap[2]}, 32'h000);
    chk("fs_ecc", {22'd0, cap[3]}, 32'h01A);
    chk("lh_wc_lsb", {22'd0, cap[5]}, 32'h018);
    chk("crc_lo", {22'd0, cap[32]}, 32'h0F0);
    chk("crc_hi", {22'd0, cap[33]}, 32'h000);
    chk("fe_tlast", {22'd0, cap[FRAME_BYTES - 1][9:8]}, 32'd1);
    chk("pre_fe_no_tlast", {22'd0, cap[FRAME_BYTES - 2][9:8]}, 32'd0);

    run_frame(0, 1'b0);
    stall_en = 1'b1;
    run_frame(0, 1'b1);
    run_frame(1, 1'b1);
    stall_en = 1'b0;
    run_frame(3, 1'b0);
    stall_en = 1'b1;
    run_frame(4, 1'b1);
    stall_en = 1'b0;
    run_frame(1, 1'b0);
    run_frame(1, 1'b0);

    @(posedge clk);
    #1;
    force dut.r_frame_num = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.r_frame_num;
    @(negedge clk);
    chk("forced_fn", {16'd0, frame_num}, 32'h0000FFFF);
    model_fn = 16'hFFFF;
    run_frame(0, 1'b0);
    chk("wrap_wc_lsb", {24'd0, cap[1][7:0]}, 32'h01);
    chk("wrap_wc_msb", {24'd0, cap[2][7:0]}, 32'h00);

    stall_en = 1'b1;
    run_frame(5, 1'b1);
    stall_en = 1'b0;
    run_frame(0, 1'b0);
    chk("post_reset_fn", {24'd0, cap[1][7:0]}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
